// File: rtl/cpu_controller_pkg.sv
// Shared types and encodings for the CPU controller: FSM states, instruction
// classes, field positions and the registered control-word layout.
package cpu_pkg;

    typedef enum logic [2:0] {
        S_WAIT,
        S_DECODE,
        S_WRITE_IMM,
        S_GET_A,
        S_GET_B,
        S_EXEC,
        S_WRITE_REG
    } state_t;

    typedef enum logic [2:0] {
        CLS_ILLEGAL,
        CLS_MOV_IMM,
        CLS_MOV_REG,
        CLS_MVN,
        CLS_ADD,
        CLS_CMP,
        CLS_AND
    } cls_t;

    localparam logic [2:0] OPC_MOV = 3'b110;
    localparam logic [2:0] OPC_ALU = 3'b101;

    localparam logic [1:0] OP_MOV_IMM = 2'b10;
    localparam logic [1:0] OP_MOV_REG = 2'b00;
    localparam logic [1:0] OP_ADD     = 2'b00;
    localparam logic [1:0] OP_CMP     = 2'b01;
    localparam logic [1:0] OP_AND     = 2'b10;
    localparam logic [1:0] OP_MVN     = 2'b11;

    localparam logic [1:0] ALU_ADD  = 2'b00;
    localparam logic [1:0] ALU_SUB  = 2'b01;
    localparam logic [1:0] ALU_AND  = 2'b10;
    localparam logic [1:0] ALU_NOTB = 2'b11;

    localparam int OPC_HI = 15;
    localparam int OPC_LO = 13;
    localparam int OP_HI  = 12;
    localparam int OP_LO  = 11;
    localparam int RN_HI  = 10;
    localparam int RN_LO  = 8;
    localparam int RD_HI  = 7;
    localparam int RD_LO  = 5;
    localparam int SH_HI  = 4;
    localparam int SH_LO  = 3;
    localparam int RM_HI  = 2;
    localparam int RM_LO  = 0;
    localparam int IMM_HI = 7;
    localparam int IMM_LO = 0;

    typedef struct packed {
        logic [1:0] op;
        logic [2:0] rn;
        logic [2:0] rd;
        logic [1:0] sh;
        logic [2:0] rm;
        logic [7:0] imm8;
        cls_t       cls;
    } dec_t;

    typedef struct packed {
        logic        wb_sel;
        logic [2:0]  w_addr;
        logic        w_en;
        logic [2:0]  r_addr;
        logic        en_a;
        logic        en_b;
        logic [1:0]  shift_op;
        logic        sel_a;
        logic        sel_b;
        logic [1:0]  alu_op;
        logic        en_c;
        logic        en_status;
        logic [15:0] datapath_in;
        logic        waiting;
        logic        illegal;
    } ctrl_t;

    function automatic logic signed [15:0] sext8(input logic signed [7:0] v);
        return {{8{v[7]}}, v};
    endfunction

endpackage

// File: rtl/cpu_controller_if.sv
// Instruction/start handshake and datapath control bundle between the
// instruction source (master) and the controller (slave).
interface cpu_controller_if;
    logic        load;
    logic        start;
    logic [15:0] instr;
    logic        wb_sel;
    logic [2:0]  w_addr;
    logic        w_en;
    logic [2:0]  r_addr;
    logic        en_A;
    logic        en_B;
    logic [1:0]  shift_op;
    logic        sel_A;
    logic        sel_B;
    logic [1:0]  ALU_op;
    logic        en_C;
    logic        en_status;
    logic [15:0] datapath_in;
    logic        waiting;
    logic        illegal;

    modport master (
        output load, start, instr,
        input  wb_sel, w_addr, w_en, r_addr, en_A, en_B, shift_op, sel_A,
               sel_B, ALU_op, en_C, en_status, datapath_in, waiting, illegal
    );

    modport slave (
        input  load, start, instr,
        output wb_sel, w_addr, w_en, r_addr, en_A, en_B, shift_op, sel_A,
               sel_B, ALU_op, en_C, en_status, datapath_in, waiting, illegal
    );
endinterface

// File: rtl/cpu_controller_instr_decoder.sv
// Purely combinational split of an instruction word into its fields and
// instruction class.
module instr_decoder
    import cpu_pkg::*;
(
    input  logic [15:0] ir,
    output dec_t        dec
);
    logic [2:0] opcode;

    assign opcode = ir[OPC_HI:OPC_LO];

    always_comb begin
        dec      = '0;
        dec.op   = ir[OP_HI:OP_LO];
        dec.rn   = ir[RN_HI:RN_LO];
        dec.rd   = ir[RD_HI:RD_LO];
        dec.sh   = ir[SH_HI:SH_LO];
        dec.rm   = ir[RM_HI:RM_LO];
        dec.imm8 = ir[IMM_HI:IMM_LO];
        case ({opcode, dec.op})
            {OPC_MOV, OP_MOV_IMM}: dec.cls = CLS_MOV_IMM;
            {OPC_MOV, OP_MOV_REG}: dec.cls = CLS_MOV_REG;
            {OPC_ALU, OP_MVN}:     dec.cls = CLS_MVN;
            {OPC_ALU, OP_ADD}:     dec.cls = CLS_ADD;
            {OPC_ALU, OP_CMP}:     dec.cls = CLS_CMP;
            {OPC_ALU, OP_AND}:     dec.cls = CLS_AND;
            default:               dec.cls = CLS_ILLEGAL;
        endcase
    end
endmodule

// File: rtl/cpu_controller.sv
// Multi-cycle instruction sequencer: holds IR, steps the FSM and drives
// registered Moore controls for the register-file/ALU datapath.
module cpu_controller
    import cpu_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    cpu_controller_if.slave bus
);
    state_t      state_p0;
    state_t      state_nxt;
    logic [15:0] ir_p0;
    logic [15:0] ir_nxt;
    dec_t        dec;
    ctrl_t       ctrl_p0;

    // Decoding the next IR lets the output register see a same-cycle load.
    assign ir_nxt = (state_p0 == S_WAIT && bus.load) ? bus.instr : ir_p0;

    instr_decoder u_dec (
        .ir  (ir_nxt),
        .dec (dec)
    );

    always_comb begin
        state_nxt = state_p0;
        case (state_p0)
            S_WAIT:      if (bus.start) state_nxt = S_DECODE;
            S_DECODE: begin
                case (dec.cls)
                    CLS_MOV_IMM:                   state_nxt = S_WRITE_IMM;
                    CLS_MOV_REG, CLS_MVN:          state_nxt = S_GET_B;
                    CLS_ADD, CLS_CMP, CLS_AND:     state_nxt = S_GET_A;
                    default:                       state_nxt = S_WAIT;
                endcase
            end
            S_WRITE_IMM: state_nxt = S_WAIT;
            S_GET_A:     state_nxt = S_GET_B;
            S_GET_B:     state_nxt = S_EXEC;
            S_EXEC:      state_nxt = (dec.cls == CLS_CMP) ? S_WAIT : S_WRITE_REG;
            S_WRITE_REG: state_nxt = S_WAIT;
            default:     state_nxt = S_WAIT;
        endcase
    end

    function automatic ctrl_t ctrl_for(input state_t st, input dec_t d);
        ctrl_t c;
        c = '0;
        case (st)
            S_WAIT:   c.waiting = 1'b1;
            S_DECODE: c.illegal = (d.cls == CLS_ILLEGAL);
            S_WRITE_IMM: begin
                c.wb_sel      = 1'b1;
                c.w_en        = 1'b1;
                c.w_addr      = d.rn;
                c.datapath_in = sext8(d.imm8);
            end
            S_GET_A: begin
                c.r_addr = d.rn;
                c.en_a   = 1'b1;
            end
            S_GET_B: begin
                c.r_addr = d.rm;
                c.en_b   = 1'b1;
            end
            S_EXEC: begin
                // MOV reg zeroes the A operand and adds, MVN uses NOT B.
                c.shift_op  = d.sh;
                c.sel_b     = 1'b0;
                c.sel_a     = (d.cls == CLS_MOV_REG || d.cls == CLS_MVN);
                c.alu_op    = (d.cls == CLS_MOV_REG) ? ALU_ADD : d.op;
                c.en_status = (d.cls == CLS_CMP);
                c.en_c      = (d.cls != CLS_CMP);
            end
            S_WRITE_REG: begin
                c.wb_sel = 1'b0;
                c.w_en   = 1'b1;
                c.w_addr = d.rd;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    // Stage p0: state, IR and the control word for the state being entered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_p0 <= S_WAIT;
            ir_p0    <= '0;
            ctrl_p0  <= ctrl_for(S_WAIT, '0);
        end else begin
            state_p0 <= state_nxt;
            ir_p0    <= ir_nxt;
            ctrl_p0  <= ctrl_for(state_nxt, dec);
        end
    end

    assign bus.wb_sel      = ctrl_p0.wb_sel;
    assign bus.w_addr      = ctrl_p0.w_addr;
    assign bus.w_en        = ctrl_p0.w_en;
    assign bus.r_addr      = ctrl_p0.r_addr;
    assign bus.en_A        = ctrl_p0.en_a;
    assign bus.en_B        = ctrl_p0.en_b;
    assign bus.shift_op    = ctrl_p0.shift_op;
    assign bus.sel_A       = ctrl_p0.sel_a;
    assign bus.sel_B       = ctrl_p0.sel_b;
    assign bus.ALU_op      = ctrl_p0.alu_op;
    assign bus.en_C        = ctrl_p0.en_c;
    assign bus.en_status   = ctrl_p0.en_status;
    assign bus.datapath_in = ctrl_p0.datapath_in;
    assign bus.waiting     = ctrl_p0.waiting;
    assign bus.illegal     = ctrl_p0.illegal;
endmodule

// File: tb/tb_cpu_controller.sv
// Directed bench: controller driving a small register-file/ALU datapath.
module tb_cpu_controller;
    logic clk = 1'b0;
    logic rst;
    logic dp_clr;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    cpu_controller_if bus();

    cpu_controller dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [15:0] rf [0:7];
    logic [15:0] reg_a, reg_b, reg_c;
    logic        z_out;
    logic [15:0] ain, bin, alu;

    function automatic logic [15:0] shf(input logic [15:0] v, input logic [1:0] s);
        case (s)
            2'b01:   return {v[14:0], 1'b0};
            2'b10:   return {1'b0, v[15:1]};
            2'b11:   return {v[15], v[15:1]};
            default: return v;
        endcase
    endfunction

    always_comb begin
        ain = bus.sel_A ? 16'h0000 : reg_a;
        bin = bus.sel_B ? bus.datapath_in : shf(reg_b, bus.shift_op);
        case (bus.ALU_op)
            2'b00:   alu = ain + bin;
            2'b01:   alu = ain - bin;
            2'b10:   alu = ain & bin;
            default: alu = ~bin;
        endcase
    end

    always @(posedge clk) begin
        if (dp_clr) begin
            for (int i = 0; i < 8; i++) rf[i] <= 16'h0000;
            reg_a <= 16'h0000;
            reg_b <= 16'h0000;
            reg_c <= 16'h0000;
            z_out <= 1'b0;
        end else begin
            if (bus.w_en)      rf[bus.w_addr] <= bus.wb_sel ? bus.datapath_in : reg_c;
            if (bus.en_A)      reg_a <= rf[bus.r_addr];
            if (bus.en_B)      reg_b <= rf[bus.r_addr];
            if (bus.en_C)      reg_c <= alu;
            if (bus.en_status) z_out <= (alu == 16'h0000);
        end
    end

    function automatic logic ctrl_any();
        return |{bus.wb_sel, bus.w_addr, bus.w_en, bus.r_addr, bus.en_A, bus.en_B,
                 bus.shift_op, bus.sel_A, bus.sel_B, bus.ALU_op, bus.en_C,
                 bus.en_status, bus.datapath_in};
    endfunction

    logic [7:1]  t_wen, t_wbsel, t_stat, t_enc, t_ill, t_wait, t_any;
    logic [2:0]  t_waddr [1:7];
    logic [15:0] t_dpin  [1:7];
    logic [1:0]  t_alu   [1:7];
    logic [1:0]  t_shift [1:7];
    logic        t_sela  [1:7];

    task automatic capture();
        for (int k = 1; k <= 7; k++) begin
            t_wen[k]   = bus.w_en;
            t_wbsel[k] = bus.wb_sel;
            t_stat[k]  = bus.en_status;
            t_enc[k]   = bus.en_C;
            t_ill[k]   = bus.illegal;
            t_wait[k]  = bus.waiting;
            t_any[k]   = ctrl_any();
            t_waddr[k] = bus.w_addr;
            t_dpin[k]  = bus.datapath_in;
            t_alu[k]   = bus.ALU_op;
            t_shift[k] = bus.shift_op;
            t_sela[k]  = bus.sel_A;
            @(negedge clk);
        end
    endtask

    task automatic issue(input logic [15:0] w);
        @(negedge clk);
        bus.instr = w;
        bus.load  = 1'b1;
        bus.start = 1'b1;
        @(negedge clk);
        bus.load  = 1'b0;
        bus.start = 1'b0;
        capture();
    endtask

    task automatic test_reset();
        rst = 1'b1; dp_clr = 1'b1;
        bus.load = 1'b1; bus.start = 1'b1; bus.instr = 16'hD007;
        repeat (3) @(negedge clk);
        bus.load = 1'b0; bus.start = 1'b0;
        n_cmp++; if (bus.waiting !== 1'b1) begin n_bad++; $display("FAIL reset_waiting: got %b want 1", bus.waiting); end
        n_cmp++; if (ctrl_any() !== 1'b0) begin n_bad++; $display("FAIL reset_ctrl_zero: got %b want 0", ctrl_any()); end
        n_cmp++; if (bus.illegal !== 1'b0) begin n_bad++; $display("FAIL reset_illegal: got %b want 0", bus.illegal); end
        rst = 1'b0; dp_clr = 1'b0;
        @(negedge clk);
        n_cmp++; if (bus.waiting !== 1'b1 || ctrl_any() !== 1'b0) begin n_bad++; $display("FAIL reset_idle_after: got wait=%b any=%b want 1/0", bus.waiting, ctrl_any()); end
    endtask

    task automatic test_mov_imm();
        issue(16'hD007);
        n_cmp++; if (t_wen !== 7'b0000010) begin n_bad++; $display("FAIL movimm_wen: got %b want 0000010", t_wen); end
        n_cmp++; if (t_wbsel !== 7'b0000010) begin n_bad++; $display("FAIL movimm_wbsel: got %b want 0000010", t_wbsel); end
        n_cmp++; if (t_waddr[2] !== 3'd0) begin n_bad++; $display("FAIL movimm_waddr: got %0d want 0", t_waddr[2]); end
        n_cmp++; if (t_dpin[2] !== 16'h0007) begin n_bad++; $display("FAIL movimm_dpin: got %h want 0007", t_dpin[2]); end
        n_cmp++; if (t_wait !== 7'b1111100) begin n_bad++; $display("FAIL movimm_waiting: got %b want 1111100", t_wait); end
        n_cmp++; if (rf[0] !== 16'h0007) begin n_bad++; $display("FAIL movimm_r0: got %h want 0007", rf[0]); end
        issue(16'hD1FE);
        n_cmp++; if (t_dpin[2] !== 16'hFFFE) begin n_bad++; $display("FAIL movneg_dpin: got %h want fffe", t_dpin[2]); end
        n_cmp++; if (rf[1] !== 16'hFFFE) begin n_bad++; $display("FAIL movneg_r1: got %h want fffe", rf[1]); end
    endtask

    task automatic test_reset_mid();
        logic seen;
        @(negedge clk);
        bus.instr = 16'hA148; bus.load = 1'b1; bus.start = 1'b1;
        @(negedge clk);
        bus.load = 1'b0; bus.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_cmp++; if (bus.en_B !== 1'b1 || bus.r_addr !== 3'd0) begin n_bad++; $display("FAIL midrst_getb: got en_B=%b r_addr=%0d want 1/0", bus.en_B, bus.r_addr); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_cmp++; if (bus.waiting !== 1'b1 || ctrl_any() !== 1'b0 || bus.illegal !== 1'b0) begin n_bad++; $display("FAIL midrst_idle: got wait=%b any=%b ill=%b want 1/0/0", bus.waiting, ctrl_any(), bus.illegal); end
        seen = 1'b0;
        for (int k = 0; k < 7; k++) begin
            seen = seen | bus.w_en | bus.en_C | bus.en_status;
            @(negedge clk);
        end
        n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL midrst_no_enable: got %b want 0", seen); end
        n_cmp++; if (rf[2] !== 16'h0000) begin n_bad++; $display("FAIL midrst_r2: got %h want 0000", rf[2]); end
    endtask

    task automatic test_add();
        issue(16'hA148);
        n_cmp++; if (t_wen !== 7'b0010000) begin n_bad++; $display("FAIL add_wen: got %b want 0010000", t_wen); end
        n_cmp++; if (t_waddr[5] !== 3'd2 || t_wbsel[5] !== 1'b0) begin n_bad++; $display("FAIL add_waddr: got %0d/%b want 2/0", t_waddr[5], t_wbsel[5]); end
        n_cmp++; if (t_enc !== 7'b0001000 || t_alu[4] !== 2'b00 || t_shift[4] !== 2'b01 || t_sela[4] !== 1'b0) begin n_bad++; $display("FAIL add_exec: got enc=%b alu=%b sh=%b selA=%b want 0001000/00/01/0", t_enc, t_alu[4], t_shift[4], t_sela[4]); end
        n_cmp++; if (t_wait !== 7'b1100000) begin n_bad++; $display("FAIL add_waiting: got %b want 1100000", t_wait); end
        n_cmp++; if (rf[2] !== 16'h000C) begin n_bad++; $display("FAIL add_r2: got %h want 000c", rf[2]); end
    endtask

    task automatic test_cmp();
        issue(16'hA800);
        n_cmp++; if (t_stat !== 7'b0001000) begin n_bad++; $display("FAIL cmp_status: got %b want 0001000", t_stat); end
        n_cmp++; if (t_wen !== 7'b0000000 || t_enc !== 7'b0000000) begin n_bad++; $display("FAIL cmp_no_write: got wen=%b enc=%b want 0/0", t_wen, t_enc); end
        n_cmp++; if (t_alu[4] !== 2'b01) begin n_bad++; $display("FAIL cmp_aluop: got %b want 01", t_alu[4]); end
        n_cmp++; if (z_out !== 1'b1) begin n_bad++; $display("FAIL cmp_z: got %b want 1", z_out); end
        n_cmp++; if (t_wait !== 7'b1110000) begin n_bad++; $display("FAIL cmp_waiting: got %b want 1110000", t_wait); end
    endtask

    task automatic test_mov_reg_mvn();
        issue(16'hC061);
        n_cmp++; if (t_wen !== 7'b0001000 || t_waddr[4] !== 3'd3) begin n_bad++; $display("FAIL movreg_wen: got %b addr=%0d want 0001000/3", t_wen, t_waddr[4]); end
        n_cmp++; if (t_alu[3] !== 2'b00 || t_sela[3] !== 1'b1) begin n_bad++; $display("FAIL movreg_exec: got alu=%b selA=%b want 00/1", t_alu[3], t_sela[3]); end
        n_cmp++; if (rf[3] !== 16'hFFFE) begin n_bad++; $display("FAIL movreg_r3: got %h want fffe", rf[3]); end
        n_cmp++; if (t_wait !== 7'b1110000) begin n_bad++; $display("FAIL movreg_waiting: got %b want 1110000", t_wait); end
        issue(16'hB880);
        n_cmp++; if (t_alu[3] !== 2'b11 || t_sela[3] !== 1'b1) begin n_bad++; $display("FAIL mvn_exec: got alu=%b selA=%b want 11/1", t_alu[3], t_sela[3]); end
        n_cmp++; if (t_wen !== 7'b0001000 || t_waddr[4] !== 3'd4) begin n_bad++; $display("FAIL mvn_wen: got %b addr=%0d want 0001000/4", t_wen, t_waddr[4]); end
        n_cmp++; if (rf[4] !== 16'hFFF8) begin n_bad++; $display("FAIL mvn_r4: got %h want fff8", rf[4]); end
    endtask

    task automatic test_illegal();
        issue(16'h0000);
        n_cmp++; if (t_ill !== 7'b0000001) begin n_bad++; $display("FAIL illegal_pulse: got %b want 0000001", t_ill); end
        n_cmp++; if (t_wait !== 7'b1111110) begin n_bad++; $display("FAIL illegal_waiting: got %b want 1111110", t_wait); end
        n_cmp++; if (t_any !== 7'b0000000) begin n_bad++; $display("FAIL illegal_no_enable: got %b want 0000000", t_any); end
    endtask

    task automatic test_start_in_exec();
        logic [10:1] wen;
        logic [10:1] wt;
        logic [2:0]  addr5;
        @(negedge clk);
        bus.instr = 16'hA148; bus.load = 1'b1; bus.start = 1'b1;
        @(negedge clk);
        bus.load = 1'b0; bus.start = 1'b0;
        addr5 = 3'd0;
        for (int k = 1; k <= 10; k++) begin
            wen[k] = bus.w_en;
            wt[k]  = bus.waiting;
            if (k == 5) addr5 = bus.w_addr;
            if (k == 4) begin bus.instr = 16'hD3AA; bus.load = 1'b1; bus.start = 1'b1; end
            if (k == 5) begin bus.load = 1'b0; bus.start = 1'b0; end
            @(negedge clk);
        end
        n_cmp++; if (wen !== 10'b0000010000) begin n_bad++; $display("FAIL exec_start_wen: got %b want 0000010000", wen); end
        n_cmp++; if (addr5 !== 3'd2) begin n_bad++; $display("FAIL exec_start_waddr: got %0d want 2", addr5); end
        n_cmp++; if (wt !== 10'b1111100000) begin n_bad++; $display("FAIL exec_start_idle: got %b want 1111100000", wt); end
        n_cmp++; if (rf[3] !== 16'hFFFE) begin n_bad++; $display("FAIL exec_start_r3: got %h want fffe", rf[3]); end
    endtask

    initial begin
        test_reset();
        test_mov_imm();
        test_reset_mid();
        test_add();
        test_cmp();
        test_mov_reg_mvn();
        test_illegal();
        test_start_in_exec();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
